// File: rtl/bitseq_capture_mc.sv
// bitseq_capture_mc: multi-channel bit-sequence recorder.
// Samples NCH inputs at a programmable bit rate after an optional trigger.
// It stores up to 2^AW bits per channel in an internal bit RAM.
// The host reads the RAM back through a registered port.
// Build option BITSEQ_CAP_SYNC2_EN: selects a 2-flop input synchronizer instead of a
// single register stage. All trigger and sample timing is measured from s_in, so the
// only difference between the two builds is the input-to-s_in latency.
module bitseq_capture_mc #(
  parameter int unsigned NCH = 4,
  parameter int unsigned AW  = 4,
  localparam int unsigned CHW = (NCH <= 1) ? 1 : $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    io_in,
  input  logic              arm,
  input  logic              abort,
  input  logic [AW:0]       len,
  input  logic [31:0]       rate_div,
  input  logic [31:0]       phase_off,
  input  logic [1:0]        trig_mode,
  input  logic [CHW-1:0]    trig_ch,
  input  logic [CHW-1:0]    rd_ch,
  input  logic [AW-1:0]     rd_addr,
  output logic              rd_bit,
  output logic              armed,
  output logic              capturing,
  output logic              done,
  output logic [AW:0]       bit_count
);

  localparam int unsigned DEPTH   = 1 << AW;
  // Channel vectors are zero-extended to a power of two so any CHW-bit index is in range.
  localparam int unsigned NCH_P   = 1 << CHW;
  localparam logic [AW:0] LEN_MAX = (AW + 1)'(DEPTH);
  localparam logic [AW:0] ONE     = (AW + 1)'(1);

  typedef enum logic [2:0] {
    StIdle,
    StArmed,
    StDelay,
    StCapture,
    StDone
  } state_e;

  state_e state_q, state_d;

  // Input path
  logic [NCH-1:0] s_in_q;
  logic [NCH-1:0] s_prev_q;

`ifdef BITSEQ_CAP_SYNC2_EN
  logic [NCH-1:0] sync_meta_q;

  // Two-flop synchronizer for inputs asynchronous to clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta_q <= '0;
      s_in_q      <= '0;
    end else begin
      sync_meta_q <= io_in;
      s_in_q      <= sync_meta_q;
    end
  end
`else
  // Single register stage; inputs are assumed synchronous to clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_in_q <= '0;
    end else begin
      s_in_q <= io_in;
    end
  end
`endif

  // One-cycle history of s_in for edge triggers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_prev_q <= '0;
    end else begin
      s_prev_q <= s_in_q;
    end
  end

  // Configuration latched at arm
  logic [AW:0]     len_q;
  logic [31:0]     rate_q;
  logic [31:0]     phase_off_q;
  logic [1:0]      trig_mode_q;
  logic [CHW-1:0]  trig_ch_q;
  logic            cfg_load;
  logic [AW:0]     len_clamped;

  assign len_clamped = (len > LEN_MAX) ? LEN_MAX : len;

  // Configuration registers, loaded only on an accepted arm.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q       <= '0;
      rate_q      <= '0;
      phase_off_q <= '0;
      trig_mode_q <= 2'b00;
      trig_ch_q   <= '0;
    end else if (cfg_load) begin
      len_q       <= len_clamped;
      rate_q      <= rate_div;
      phase_off_q <= phase_off;
      trig_mode_q <= trig_mode;
      trig_ch_q   <= trig_ch;
    end
  end

  // Trigger detection on the watched channel
  logic [NCH_P-1:0] s_in_ext;
  logic [NCH_P-1:0] s_prev_ext;
  logic             trig_cur;
  logic             trig_prev;
  logic             trig_fire;

  assign s_in_ext   = NCH_P'(s_in_q);
  assign s_prev_ext = NCH_P'(s_prev_q);
  assign trig_cur   = s_in_ext[trig_ch_q];
  assign trig_prev  = s_prev_ext[trig_ch_q];

  // Decode the latched trigger mode into a single fire strobe.
  always_comb begin
    trig_fire = 1'b0;
    unique case (trig_mode_q)
      2'b00:   trig_fire = 1'b1;
      2'b01:   trig_fire = trig_cur & ~trig_prev;
      2'b10:   trig_fire = ~trig_cur & trig_prev;
      2'b11:   trig_fire = trig_cur;
      default: trig_fire = 1'b0;
    endcase
  end

  // Counters
  logic [31:0] phase_cnt_q, phase_cnt_d;
  logic [31:0] tick_q, tick_d;
  logic [AW:0] bit_count_q, bit_count_d;
  logic        sample;

  // Next-state logic: abort has priority over everything, including arm.
  always_comb begin
    state_d     = state_q;
    phase_cnt_d = phase_cnt_q;
    tick_d      = tick_q;
    bit_count_d = bit_count_q;
    cfg_load    = 1'b0;
    sample      = 1'b0;
    if (abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (arm) begin
            cfg_load    = 1'b1;
            bit_count_d = '0;
            state_d     = (len == '0) ? StDone : StArmed;
          end
        end
        StArmed: begin
          if (trig_fire) begin
            // With no phase offset the first sample lands on the cycle after the trigger,
            // so DELAY is skipped entirely.
            if (phase_off_q == '0) begin
              state_d = StCapture;
              tick_d  = '0;
            end else begin
              state_d     = StDelay;
              phase_cnt_d = phase_off_q;
            end
          end
        end
        StDelay: begin
          // DELAY lasts exactly phase_off cycles; leave on the last one.
          if (phase_cnt_q <= 32'd1) begin
            state_d     = StCapture;
            phase_cnt_d = '0;
            tick_d      = '0;
          end else begin
            phase_cnt_d = phase_cnt_q - 32'd1;
          end
        end
        StCapture: begin
          if (tick_q == '0) begin
            sample      = 1'b1;
            bit_count_d = bit_count_q + ONE;
            tick_d      = rate_q;
            if (bit_count_d == len_q) begin
              state_d = StDone;
            end
          end else begin
            tick_d = tick_q - 32'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // FSM state and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      phase_cnt_q <= '0;
      tick_q      <= '0;
      bit_count_q <= '0;
    end else begin
      state_q     <= state_d;
      phase_cnt_q <= phase_cnt_d;
      tick_q      <= tick_d;
      bit_count_q <= bit_count_d;
    end
  end

  // Bit RAM: one word per bit index holding all channels; contents are not reset.
  logic [NCH-1:0] mem [DEPTH];

  // All channels are written together at the current bit index.
  always_ff @(posedge clk) begin
    if (sample) begin
      mem[bit_count_q[AW-1:0]] <= s_in_q;
    end
  end

  logic [NCH_P-1:0] rd_word;
  logic             rd_bit_q;

  assign rd_word = NCH_P'(mem[rd_addr]);

  // Registered readback, legal in any state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_bit_q <= 1'b0;
    end else begin
      rd_bit_q <= rd_word[rd_ch];
    end
  end

  assign rd_bit    = rd_bit_q;
  assign armed     = (state_q == StArmed);
  assign capturing = (state_q == StDelay) || (state_q == StCapture);
  assign done      = (state_q == StDone);
  assign bit_count = bit_count_q;

endmodule

// File: tb/tb_bitseq_capture_mc.sv
// Self-checking bench for bitseq_capture_mc.
// The reference model records every io_in value per cycle. From that record it derives
// s_in, the trigger cycle and the sample cycles arithmetically, and it keeps its own
// copy of the expected RAM.
module tb_bitseq_capture_mc;

  localparam int NCH   = 4;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
`ifdef BITSEQ_CAP_SYNC2_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  io_in = '0;
  logic        arm = 1'b0;
  logic        abort = 1'b0;
  logic [4:0]  len = '0;
  logic [31:0] rate_div = '0;
  logic [31:0] phase_off = '0;
  logic [1:0]  trig_mode = '0;
  logic [1:0]  trig_ch = '0;
  logic [1:0]  rd_ch = '0;
  logic [3:0]  rd_addr = '0;
  logic        rd_bit;
  logic        armed;
  logic        capturing;
  logic        done;
  logic [4:0]  bit_count;

  bitseq_capture_mc #(.NCH(NCH), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .io_in     (io_in),
    .arm       (arm),
    .abort     (abort),
    .len       (len),
    .rate_div  (rate_div),
    .phase_off (phase_off),
    .trig_mode (trig_mode),
    .trig_ch   (trig_ch),
    .rd_ch     (rd_ch),
    .rd_addr   (rd_addr),
    .rd_bit    (rd_bit),
    .armed     (armed),
    .capturing (capturing),
    .done      (done),
    .bit_count (bit_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int wave_base = 0;
  logic [3:0] hist [0:32767];
  int exp_mem [NCH][DEPTH];
  bit exp_vld [NCH][DEPTH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance one clock; the new io value is the one held during the new cycle.
  task automatic step(input logic [3:0] nio);
    @(posedge clk);
    #1;
    cyc++;
    io_in = nio;
    hist[cyc] = nio;
  endtask

  // Synchronised input as seen by the capture logic in cycle c.
  function automatic logic [3:0] s_at(input int c);
    if (c - LAT < 0) return 4'b0;
    return hist[c - LAT];
  endfunction

  function automatic bit trig_ok(input int tm, input int tc, input logic [3:0] cur,
                                 input logic [3:0] prv);
    case (tm)
      0:       return 1'b1;
      1:       return cur[tc] && !prv[tc];
      2:       return !cur[tc] && prv[tc];
      default: return cur[tc];
    endcase
  endfunction

  // kind 0: random, 1: constant, 2: ch0 square wave with 50-cycle half period
  function automatic logic [3:0] gen_io(input int kind, input logic [3:0] cur, input int c);
    logic [31:0] r;
    r = $urandom;
    case (kind)
      0:       return r[3:0];
      1:       return cur;
      default: return {r[3:1], 1'(((c - wave_base) / 50) % 2)};
    endcase
  endfunction

  task automatic run_capture(input int ln, input int rdv, input int po, input int tm,
                             input int tc, input int kind, input logic [3:0] io0);
    int a, t, n, s0, done_c, armed_fall;
    logic [3:0] cur;
    logic [3:0] sv;
    len = 5'(ln); rate_div = 32'(rdv); phase_off = 32'(po);
    trig_mode = 2'(tm); trig_ch = 2'(tc);
    arm = 1'b1;
    a = cyc;
    wave_base = a;
    n = (ln > DEPTH) ? DEPTH : ln;
    cur = io0;
    step(cur);
    arm = 1'b0;
    check("arm armed", armed, (n > 0));
    check("arm done", done, (n == 0));
    check("arm bit_count clear", bit_count, 0);
    done_c = -1;
    armed_fall = -1;
    for (int i = 0; i < 4000 && done_c < 0; i++) begin
      if (armed_fall < 0 && !armed) armed_fall = cyc;
      if (done) done_c = cyc;
      else begin
        cur = gen_io(kind, cur, cyc);
        step(cur);
      end
    end
    check("run finished", (done_c >= 0), 1);
    if (n == 0) begin
      check("len0 done cycle", done_c, a + 1);
    end else begin
      t = -1;
      for (int c = a + 1; c <= cyc && t < 0; c++) begin
        if (trig_ok(tm, tc, s_at(c), s_at(c - 1))) t = c;
      end
      check("trigger found", (t >= 0), 1);
      if (t >= 0) begin
        s0 = t + po + 1;
        check("armed fall cycle", armed_fall, t + 1);
        check("done cycle", done_c, s0 + (n - 1) * (rdv + 1) + 1);
        for (int k = 0; k < n; k++) begin
          sv = s_at(s0 + k * (rdv + 1));
          for (int ch = 0; ch < NCH; ch++) begin
            exp_mem[ch][k] = int'(sv[ch]);
            exp_vld[ch][k] = 1'b1;
          end
        end
      end
    end
    check("done bit_count", bit_count, n);
    check("done capturing", capturing, 0);
  endtask

  task automatic readback(input string tag);
    for (int ch = 0; ch < NCH; ch++) begin
      for (int ad = 0; ad < DEPTH; ad++) begin
        if (exp_vld[ch][ad]) begin
          rd_ch = 2'(ch);
          rd_addr = 4'(ad);
          step(io_in);
          check($sformatf("%s ch%0d[%0d]", tag, ch, ad), rd_bit, exp_mem[ch][ad]);
        end
      end
    end
  endtask

  task automatic run_abort();
    int a, s0;
    logic [3:0] cur;
    logic [3:0] sv;
    len = 5'd16; rate_div = 32'd3; phase_off = 32'd2; trig_mode = 2'd0; trig_ch = 2'd0;
    arm = 1'b1;
    a = cyc;
    cur = gen_io(0, cur, cyc);
    step(cur);
    arm = 1'b0;
    for (int i = 0; i < 500 && bit_count != 5; i++) begin
      cur = gen_io(0, cur, cyc);
      step(cur);
    end
    check("abort reach 5", bit_count, 5);
    abort = 1'b1;
    arm = 1'b1;
    step(cur);
    abort = 1'b0;
    arm = 1'b0;
    check("abort armed", armed, 0);
    check("abort capturing", capturing, 0);
    check("abort done", done, 0);
    check("abort bit_count hold", bit_count, 5);
    step(cur);
    check("abort arm ignored", armed, 0);
    check("abort bit_count hold2", bit_count, 5);
    s0 = a + 1 + 2 + 1;
    for (int k = 0; k < 5; k++) begin
      sv = s_at(s0 + k * 4);
      for (int ch = 0; ch < NCH; ch++) begin
        exp_mem[ch][k] = int'(sv[ch]);
        exp_vld[ch][k] = 1'b1;
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] r;
    for (int i = 0; i < 32768; i++) hist[i] = '0;
    for (int ch = 0; ch < NCH; ch++)
      for (int ad = 0; ad < DEPTH; ad++) begin
        exp_mem[ch][ad] = 0;
        exp_vld[ch][ad] = 1'b0;
      end

    repeat (3) step(4'b0);
    check("reset armed", armed, 0);
    check("reset capturing", capturing, 0);
    check("reset done", done, 0);
    check("reset bit_count", bit_count, 0);
    check("reset rd_bit", rd_bit, 0);
    rst_n = 1'b1;
    repeat (4) step(4'b0);
    check("idle armed", armed, 0);

    // Loopback-style capture of an alternating pattern on ch0.
    run_capture(10, 49, 25, 1, 0, 2, 4'b0);
    readback("loop");
    for (int k = 0; k < 10; k++) begin
      rd_ch = 2'd0;
      rd_addr = 4'(k);
      step(io_in);
      check($sformatf("loop pattern bit%0d", k), rd_bit, (k % 2 == 0));
    end

    // Immediate trigger, one sample per clock, ch2 held high.
    repeat (3) step(4'b0100);
    run_capture(16, 0, 0, 0, 0, 1, 4'b0100);
    readback("const");
    rd_ch = 2'd2; rd_addr = 4'd15;
    step(io_in);
    check("const ch2 last", rd_bit, 1);

    // Zero length: done right away, RAM untouched; then abort clears done.
    run_capture(0, 3, 2, 0, 0, 0, 4'b1111);
    readback("len0");
    abort = 1'b1;
    step(io_in);
    abort = 1'b0;
    check("abort from done", done, 0);

    // Length above depth is clamped.
    run_capture(20, 1, 3, 1, 1, 0, 4'b0);
    readback("clamp");

    // Abort mid-capture with simultaneous arm, then re-arm.
    run_abort();
    readback("abort");
    run_capture(8, 1, 1, 0, 0, 0, 4'b0);
    readback("rearm");

    // Falling-edge trigger on ch3, with and without phase offset.
    run_capture(12, 2, 4, 2, 3, 0, 4'b1000);
    run_capture(6, 0, 0, 2, 3, 0, 4'b1000);
    readback("fall");

    // Randomized runs.
    for (int i = 0; i < 12; i++) begin
      r = $urandom;
      run_capture(int'($urandom_range(0, 20)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 5)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), 0, r[3:0]);
      readback("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
